// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: key channel state encoding,
// sample-tick divider derivation and a width helper.
package debounce_pkg;

    // Key channel states; bit 1 doubles as the debounced level.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_HELD         = 2'b11,
        ST_RELEASE_WAIT = 2'b10
    } key_state_e;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    // Clock cycles per 1 kHz sample tick.
    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounced button channel: two-flop synchroniser, press/release FSM
// counting shared sample ticks, and registered level/press/release outputs.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int               CNT_W    = clog2(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             s;
    key_state_e       state_q;
    key_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;

    // State and tick counter register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: an input edge always wins over a tick in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the transition about to be taken, then registered.
    always_comb begin
        level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
        press_d = (state_q == ST_PRESS_WAIT) && (state_d == ST_HELD);
        rel_d   = (state_q == ST_RELEASE_WAIT) && (state_d == ST_IDLE);
    end

    // Output register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/input_debounce.sv
// Conditions raw board inputs: per-button debounce channels plus a switch
// word debounced as one unit, all paced by a shared 1 kHz sample tick.
module input_debounce
    import debounce_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int N_KEYS      = 2,
    parameter int SW_W        = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [SW_W-1:0]   sw_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [SW_W-1:0]   sw_stable,
    output logic              sw_changed
);

    // CLK_HZ must be a multiple of 1000 and >= 2000; DEBOUNCE_MS >= 2.
    localparam int                TICK_DIV  = tick_div(CLK_HZ);
    localparam int                TICK_W    = clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam int                CNT_W     = clog2(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_MS - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              tick;

    logic [SW_W-1:0]   sw_sync1_q;
    logic [SW_W-1:0]   sw_sync2_q;
    logic [SW_W-1:0]   s_w;
    logic              wait_q;
    logic              wait_d;
    logic [SW_W-1:0]   cand_q;
    logic [SW_W-1:0]   cand_d;
    logic [CNT_W-1:0]  sw_cnt_q;
    logic [CNT_W-1:0]  sw_cnt_d;
    logic [SW_W-1:0]   sw_stable_q;
    logic [SW_W-1:0]   sw_stable_d;
    logic              sw_changed_q;
    logic              sw_changed_d;

    // Sample tick: one cycle high at the top of each divider period.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    // Tick divider register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // One independent debounce channel per button.
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        debounce_ch #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_ch (
            .clk  (clk),
            .clr  (clr),
            .tick (tick),
            .raw  (key_raw[gi]),
            .level(key_level[gi]),
            .press(key_press[gi]),
            .rel  (key_release[gi])
        );
    end

    // Bring the switch word into the clk domain.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= sw_raw;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    assign s_w = sw_sync2_q;

    // Switch word debouncer: any movement of the word restarts the wait, so
    // intermediate values seen while the switches settle are never published.
    always_comb begin
        wait_d       = wait_q;
        cand_d       = cand_q;
        sw_cnt_d     = sw_cnt_q;
        sw_stable_d  = sw_stable_q;
        sw_changed_d = 1'b0;
        if (!wait_q) begin
            if (s_w != sw_stable_q) begin
                wait_d   = 1'b1;
                cand_d   = s_w;
                sw_cnt_d = '0;
            end
        end else if (s_w == sw_stable_q) begin
            wait_d   = 1'b0;
            sw_cnt_d = '0;
        end else if (s_w != cand_q) begin
            cand_d   = s_w;
            sw_cnt_d = '0;
        end else if (tick) begin
            if (sw_cnt_q == CNT_LAST) begin
                wait_d       = 1'b0;
                sw_cnt_d     = '0;
                sw_stable_d  = cand_q;
                sw_changed_d = 1'b1;
            end else begin
                sw_cnt_d = sw_cnt_q + CNT_W'(1);
            end
        end
    end

    // Switch debouncer state and output register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wait_q       <= 1'b0;
            cand_q       <= '0;
            sw_cnt_q     <= '0;
            sw_stable_q  <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            wait_q       <= wait_d;
            cand_q       <= cand_d;
            sw_cnt_q     <= sw_cnt_d;
            sw_stable_q  <= sw_stable_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign sw_stable  = sw_stable_q;
    assign sw_changed = sw_changed_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with a 10-cycle tick and a 4-tick window.
module tb_input_debounce;

    logic       clk;
    logic       clr;
    logic [1:0] key_raw;
    logic [3:0] sw_raw;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [3:0] sw_stable;
    logic       sw_changed;

    input_debounce #(
        .CLK_HZ     (10_000),
        .DEBOUNCE_MS(4),
        .N_KEYS     (2),
        .SW_W       (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .key_raw    (key_raw),
        .sw_raw     (sw_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .sw_stable  (sw_stable),
        .sw_changed (sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Pulse monitor, sampled just after each rising edge.
    int press_cnt [2];
    int rel_cnt   [2];
    int last_press[2];
    int last_rel  [2];
    int chg_cnt;
    int last_chg;
    bit seen3;
    bit both_seen = 1'b0;
    bit lvl0_drop;

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (key_press[i] === 1'b1) begin
                press_cnt[i]++;
                last_press[i] = cyc;
            end
            if (key_release[i] === 1'b1) begin
                rel_cnt[i]++;
                last_rel[i] = cyc;
            end
        end
        if (sw_changed === 1'b1) begin
            chg_cnt++;
            last_chg = cyc;
        end
        if (sw_stable == 4'h3) seen3 = 1'b1;
        if ((key_press & key_release) != 2'b00) both_seen = 1'b1;
        if (key_level[0] !== 1'b1) lvl0_drop = 1'b1;
    end

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            press_cnt[i]  = 0;
            rel_cnt[i]    = 0;
            last_press[i] = -100000;
            last_rel[i]   = -100000;
        end
        chg_cnt   = 0;
        last_chg  = -100000;
        seen3     = 1'b0;
        lvl0_drop = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int val, input int lo, input int hi);
        total++;
        if (val < lo || val > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] key;
        logic [3:0] sw;
        int         ncyc;
        logic [1:0] level;
        logic [3:0] stable;
        int         press0;
        int         rel0;
        int         press1;
        int         rel1;
        int         chg;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int edge_cyc;

    initial begin
        // Each vector starts from the state left by the previous one.
        vecs[0] = '{2'b01, 4'h0, 60, 2'b01, 4'h0, 1, 0, 0, 0, 0};
        vecs[1] = '{2'b00, 4'h0, 60, 2'b00, 4'h0, 0, 1, 0, 0, 0};
        vecs[2] = '{2'b10, 4'h0, 60, 2'b10, 4'h0, 0, 0, 1, 0, 0};
        vecs[3] = '{2'b11, 4'h0, 60, 2'b11, 4'h0, 1, 0, 0, 0, 0};
        vecs[4] = '{2'b00, 4'h0, 60, 2'b00, 4'h0, 0, 1, 0, 1, 0};
        vecs[5] = '{2'b00, 4'hA, 60, 2'b00, 4'hA, 0, 0, 0, 0, 1};
        vecs[6] = '{2'b00, 4'h5, 60, 2'b00, 4'h5, 0, 0, 0, 0, 1};
        vecs[7] = '{2'b11, 4'h5, 20, 2'b00, 4'h5, 0, 0, 0, 0, 0};
        vecs[8] = '{2'b00, 4'h5, 60, 2'b00, 4'h5, 0, 0, 0, 0, 0};
        vecs[9] = '{2'b00, 4'h0, 60, 2'b00, 4'h0, 0, 0, 0, 0, 1};

        clear_mon();

        // Reset with all inputs held active.
        clr     = 1'b1;
        key_raw = 2'b11;
        sw_raw  = 4'hF;
        #1 clr  = 1'b0;
        cycles(10);
        check("rst_level", key_level, 2'b00);
        check("rst_press", key_press, 2'b00);
        check("rst_release", key_release, 2'b00);
        check("rst_stable", sw_stable, 4'h0);
        check("rst_changed", sw_changed, 1'b0);
        clear_mon();
        clr      = 1'b1;
        edge_cyc = cyc;
        cycles(50);
        check("rst_press0_cnt", press_cnt[0], 1);
        check("rst_press1_cnt", press_cnt[1], 1);
        check("rst_press_same", last_press[1] - last_press[0], 0);
        check_rng("rst_press_lat", last_press[0] - edge_cyc, 33, 43);
        check("rst_chg_cnt", chg_cnt, 1);
        check_rng("rst_chg_lat", last_chg - edge_cyc, 33, 43);
        check("rst_stable_f", sw_stable, 4'hF);
        check("rst_level_11", key_level, 2'b11);
        $display("reset release: press at +%0d, sw_changed at +%0d",
                 last_press[0] - edge_cyc, last_chg - edge_cyc);

        // Return to a quiet baseline.
        key_raw = 2'b00;
        sw_raw  = 4'h0;
        clr     = 1'b0;
        cycles(3);
        clr = 1'b1;
        cycles(5);

        for (int v = 0; v < NV; v++) begin
            clear_mon();
            key_raw = vecs[v].key;
            sw_raw  = vecs[v].sw;
            cycles(vecs[v].ncyc);
            check($sformatf("v%0d_level", v), key_level, vecs[v].level);
            check($sformatf("v%0d_stable", v), sw_stable, vecs[v].stable);
            check($sformatf("v%0d_press0", v), press_cnt[0], vecs[v].press0);
            check($sformatf("v%0d_rel0", v), rel_cnt[0], vecs[v].rel0);
            check($sformatf("v%0d_press1", v), press_cnt[1], vecs[v].press1);
            check($sformatf("v%0d_rel1", v), rel_cnt[1], vecs[v].rel1);
            check($sformatf("v%0d_chg", v), chg_cnt, vecs[v].chg);
            $display("vec %0d: key_raw=%b sw_raw=%h -> level=%b stable=%h",
                     v, vecs[v].key, vecs[v].sw, key_level, sw_stable);
        end

        // Clean press on key 0.
        clear_mon();
        key_raw  = 2'b01;
        edge_cyc = cyc;
        cycles(100);
        check("clean_press_cnt", press_cnt[0], 1);
        check_rng("clean_press_lat", last_press[0] - edge_cyc, 33, 43);
        check("clean_level", key_level, 2'b01);
        check("clean_key1_press", press_cnt[1], 0);
        check("clean_rel", rel_cnt[0] + rel_cnt[1], 0);
        $display("clean press: latency %0d", last_press[0] - edge_cyc);
        key_raw = 2'b00;
        cycles(60);

        // Bouncing press: nine toggles 7 cycles apart, ending high.
        clear_mon();
        for (int k = 0; k < 9; k++) begin
            key_raw[0] = ~key_raw[0];
            edge_cyc   = cyc;
            if (k < 8) cycles(7);
        end
        cycles(60);
        check("bounce_press_cnt", press_cnt[0], 1);
        check_rng("bounce_press_lat", last_press[0] - edge_cyc, 33, 43);
        check("bounce_rel_cnt", rel_cnt[0], 0);
        check("bounce_level", key_level, 2'b01);
        $display("bounce: latency after final edge %0d", last_press[0] - edge_cyc);

        // Short low glitch while held is rejected.
        clear_mon();
        key_raw[0] = 1'b0;
        cycles(15);
        key_raw[0] = 1'b1;
        cycles(60);
        check("glitch_level_drop", lvl0_drop, 1'b0);
        check("glitch_press", press_cnt[0], 0);
        check("glitch_rel", rel_cnt[0], 0);
        $display("release glitch: level held=%b", ~lvl0_drop);

        // Real release.
        clear_mon();
        key_raw[0] = 1'b0;
        edge_cyc   = cyc;
        cycles(60);
        check("release_cnt", rel_cnt[0], 1);
        check_rng("release_lat", last_rel[0] - edge_cyc, 33, 43);
        check("release_press", press_cnt[0], 0);
        check("release_level", key_level, 2'b00);
        $display("release: latency %0d", last_rel[0] - edge_cyc);

        // Switch word moving 0 -> 3 -> 7 publishes only 7.
        clear_mon();
        sw_raw = 4'h3;
        cycles(20);
        sw_raw   = 4'h7;
        edge_cyc = cyc;
        cycles(60);
        check("sw_chg_cnt", chg_cnt, 1);
        check_rng("sw_chg_lat", last_chg - edge_cyc, 33, 43);
        check("sw_stable_7", sw_stable, 4'h7);
        check("sw_never_3", seen3, 1'b0);
        $display("switch word: stable=%h latency %0d", sw_stable, last_chg - edge_cyc);

        // Reset in the middle of a press wait.
        key_raw[0] = 1'b1;
        cycles(15);
        clear_mon();
        clr = 1'b0;
        cycles(3);
        check("midrst_level", key_level, 2'b00);
        check("midrst_stable", sw_stable, 4'h0);
        clr      = 1'b1;
        edge_cyc = cyc;
        cycles(25);
        check("midrst_early_press", press_cnt[0], 0);
        cycles(35);
        check("midrst_press_cnt", press_cnt[0], 1);
        check_rng("midrst_press_lat", last_press[0] - edge_cyc, 33, 43);
        $display("reset mid-wait: press %0d cycles after reset release",
                 last_press[0] - edge_cyc);

        check("press_release_overlap", both_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
